// File: rtl/store_buffer_fwd_pkg.sv
// Shared types and width helpers for the store buffer and its forwarding search.
// Entry lifecycle: FREE -> ALLOC -> READY -> COMMITTED -> FREE.
package store_buffer_fwd_pkg;

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_ALLOC     = 2'd1,
    ST_READY     = 2'd2,
    ST_COMMITTED = 2'd3
  } entry_state_e;

  localparam int SB_DEPTH  = 16;
  localparam int SB_ADDR_W = 8;
  localparam int SB_DATA_W = 32;
  localparam int SB_TAG_W  = $clog2(SB_DEPTH);

  // Number of byte-offset address bits inside one data word.
  function automatic int word_lsb(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/sq_fwd_select.sv
// Combinational age-masked search: among entries from head up to ld_age, stall on any
// pending ALLOC, otherwise pick the youngest word match and decide hit or partial stall.
module sq_fwd_select
  import store_buffer_fwd_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  localparam int TAG_W = $clog2(DEPTH),
  localparam int BE_W  = DATA_W / 8
) (
  input  logic                          ld_valid,
  input  logic [ADDR_W-1:0]             ld_addr,
  input  logic [BE_W-1:0]               ld_be,
  input  logic [TAG_W:0]                ld_age,
  input  logic [TAG_W:0]                head,
  input  logic [DEPTH-1:0]              busy,
  input  logic [DEPTH-1:0]              alloc_pend,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  ent_data,
  input  logic [DEPTH-1:0][BE_W-1:0]    ent_be,
  output logic                          fwd_hit,
  output logic [DATA_W-1:0]             fwd_data,
  output logic                          fwd_stall
);

  localparam int WL = word_lsb(DATA_W);
  localparam logic [TAG_W:0] DEPTH_W = (TAG_W+1)'(DEPTH);

  logic [TAG_W:0]    span;
  logic [TAG_W-1:0]  idx;
  logic              any_alloc;
  logic              match_found;
  logic              sel_cover;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    span        = ld_age - head;
    idx         = '0;
    any_alloc   = 1'b0;
    match_found = 1'b0;
    sel_cover   = 1'b0;
    sel_data    = '0;
    // A span beyond DEPTH means the load is older than everything still buffered.
    for (int off = 0; off < DEPTH; off++) begin
      idx = head[TAG_W-1:0] + TAG_W'(off);
      if (span <= DEPTH_W && (TAG_W+1)'(off) < span && busy[idx]) begin
        if (alloc_pend[idx]) begin
          any_alloc = 1'b1;
        end else if (ent_addr[idx][ADDR_W-1:WL] == ld_addr[ADDR_W-1:WL] &&
                     |(ent_be[idx] & ld_be)) begin
          match_found = 1'b1;
          sel_cover   = ((ent_be[idx] & ld_be) == ld_be);
          sel_data    = ent_data[idx];
        end
      end
    end
  end

  always_comb begin
    fwd_hit   = ld_valid && !any_alloc && match_found && sel_cover;
    fwd_stall = ld_valid && (any_alloc || (match_found && !sel_cover));
    fwd_data  = fwd_hit ? sel_data : '0;
  end

endmodule

// File: rtl/store_buffer_fwd.sv
// Circular store queue with in-order alloc/exec/commit/drain and combinational
// store-to-load forwarding; flush discards everything younger than the commit pointer.
module store_buffer_fwd
  import store_buffer_fwd_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  localparam int TAG_W = $clog2(DEPTH),
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              exec_valid,
  input  logic [TAG_W-1:0]  exec_tag,
  input  logic [ADDR_W-1:0] exec_addr,
  input  logic [DATA_W-1:0] exec_data,
  input  logic [BE_W-1:0]   exec_be,
  input  logic              commit_valid,
  output logic              drain_valid,
  output logic [ADDR_W-1:0] drain_addr,
  output logic [DATA_W-1:0] drain_data,
  output logic [BE_W-1:0]   drain_be,
  input  logic              drain_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [BE_W-1:0]   ld_be,
  input  logic [TAG_W:0]    ld_age,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd_stall,
  input  logic              flush,
  output logic [TAG_W:0]    tail_snap,
  output logic [TAG_W:0]    count,
  output logic              full,
  output logic              empty,
  output logic              err
);

  entry_state_e state_q [DEPTH];
  entry_state_e state_d [DEPTH];
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [DEPTH-1:0][BE_W-1:0]   be_q, be_d;
  logic [TAG_W:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
  logic           err_q, err_d;

  logic [TAG_W-1:0] head_idx, cmt_idx, tail_idx;
  logic             alloc_fire, drain_fire;
  logic [DEPTH-1:0] busy, alloc_pend;

  assign head_idx = head_q[TAG_W-1:0];
  assign cmt_idx  = cmt_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];

  // Occupancy comes only from registered pointers, so a same-cycle drain does not open a slot.
  assign count       = tail_q - head_q;
  assign full        = (count == (TAG_W+1)'(DEPTH));
  assign empty       = (count == '0);
  assign tail_snap   = tail_q;
  assign alloc_ready = !full && !flush;
  assign alloc_tag   = tail_idx;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign err         = err_q;

  assign drain_valid = (state_q[head_idx] == ST_COMMITTED);
  assign drain_addr  = addr_q[head_idx];
  assign drain_data  = data_q[head_idx];
  assign drain_be    = be_q[head_idx];
  assign drain_fire  = drain_valid && drain_ready;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flags
    assign busy[gi]       = (state_q[gi] != ST_FREE);
    assign alloc_pend[gi] = (state_q[gi] == ST_ALLOC);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    head_d  = head_q;
    cmt_d   = cmt_q;
    tail_d  = tail_q;
    err_d   = err_q;

    if (exec_valid) begin
      if (state_q[exec_tag] == ST_ALLOC) begin
        state_d[exec_tag] = ST_READY;
        addr_d[exec_tag]  = exec_addr;
        data_d[exec_tag]  = exec_data;
        be_d[exec_tag]    = exec_be;
      end else begin
        err_d = 1'b1;
      end
    end

    if (commit_valid) begin
      if (cmt_q != tail_q && state_q[cmt_idx] == ST_READY) begin
        state_d[cmt_idx] = ST_COMMITTED;
        cmt_d            = cmt_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    // Flush sees the commit already applied, so a same-cycle commit survives.
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (state_d[i] == ST_ALLOC || state_d[i] == ST_READY) state_d[i] = ST_FREE;
      end
      tail_d = cmt_d;
    end

    if (alloc_fire) begin
      state_d[tail_idx] = ST_ALLOC;
      tail_d            = tail_q + 1'b1;
    end

    if (drain_fire) begin
      state_d[head_idx] = ST_FREE;
      head_d            = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= ST_FREE;
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      cmt_q   <= cmt_d;
      tail_q  <= tail_d;
      err_q   <= err_d;
    end
  end

  // Payload is only meaningful behind a non-FREE state, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    be_q   <= be_d;
  end

  sq_fwd_select #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd_select (
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_be      (ld_be),
    .ld_age     (ld_age),
    .head       (head_q),
    .busy       (busy),
    .alloc_pend (alloc_pend),
    .ent_addr   (addr_q),
    .ent_data   (data_q),
    .ent_be     (be_q),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
    .fwd_stall  (fwd_stall)
  );

endmodule

// File: tb/tb_store_buffer_fwd.sv
// Store buffer bench: queue-based reference model compared every cycle, directed
// scenarios with literal expectations, then a randomized alloc/exec/commit/drain/load mix.
module tb_store_buffer_fwd;

  localparam int DEPTH = 16;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int BW    = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          alloc_valid, alloc_ready;
  logic [TW-1:0] alloc_tag;
  logic          exec_valid;
  logic [TW-1:0] exec_tag;
  logic [AW-1:0] exec_addr;
  logic [DW-1:0] exec_data;
  logic [BW-1:0] exec_be;
  logic          commit_valid;
  logic          drain_valid, drain_ready;
  logic [AW-1:0] drain_addr;
  logic [DW-1:0] drain_data;
  logic [BW-1:0] drain_be;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [BW-1:0] ld_be;
  logic [TW:0]   ld_age;
  logic          fwd_hit, fwd_stall;
  logic [DW-1:0] fwd_data;
  logic          flush;
  logic [TW:0]   tail_snap, count;
  logic          full, empty, err;

  always #5 clk = ~clk;

  store_buffer_fwd #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .exec_valid(exec_valid), .exec_tag(exec_tag), .exec_addr(exec_addr),
    .exec_data(exec_data), .exec_be(exec_be),
    .commit_valid(commit_valid),
    .drain_valid(drain_valid), .drain_addr(drain_addr), .drain_data(drain_data),
    .drain_be(drain_be), .drain_ready(drain_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be), .ld_age(ld_age),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .flush(flush), .tail_snap(tail_snap), .count(count),
    .full(full), .empty(empty), .err(err)
  );

  // Reference model: queue front is the oldest buffered store. st: 1=alloc 2=ready 3=committed.
  typedef struct {
    int            st;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] be;
  } ent_t;

  ent_t mq[$];
  int   m_head;
  int   m_ncmt;
  bit   m_err;
  int   n_drained;
  int   n_cmp;
  int   n_bad;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int m_tail();
    return m_head + mq.size();
  endfunction

  function automatic void model_fwd(output bit hit, output bit stall, output logic [DW-1:0] data);
    int n;
    hit = 0; stall = 0; data = '0;
    if (!ld_valid) return;
    n = (int'(ld_age) - (m_head % 32) + 32) % 32;
    if (n > DEPTH) n = 0;
    if (n > mq.size()) n = mq.size();
    for (int k = 0; k < n; k++) if (mq[k].st == 1) stall = 1;
    if (stall) return;
    for (int k = n - 1; k >= 0; k--) begin
      if (mq[k].a[AW-1:2] == ld_addr[AW-1:2] && (mq[k].be & ld_be) != 0) begin
        if ((mq[k].be & ld_be) == ld_be) begin
          hit  = 1;
          data = mq[k].d;
        end else begin
          stall = 1;
        end
        return;
      end
    end
  endfunction

  // Per-cycle compare and model advance, sampled on the falling edge.
  int            c_sz, c_tl, c_ke;
  bit            c_dv, c_eok, c_cok, c_aok, c_dok, e_hit, e_stall;
  logic [DW-1:0] e_data;
  ent_t          c_new;

  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        mq.delete();
        m_head = 0; m_ncmt = 0; m_err = 0;
      end else begin
        c_sz = mq.size();
        c_tl = m_head + c_sz;
        chk("count", 64'(count), 64'(c_sz));
        chk("full", 64'(full), 64'(c_sz == DEPTH));
        chk("empty", 64'(empty), 64'(c_sz == 0));
        chk("alloc_ready", 64'(alloc_ready), 64'(c_sz != DEPTH && !flush));
        if (c_sz != DEPTH) chk("alloc_tag", 64'(alloc_tag), 64'(c_tl % DEPTH));
        chk("tail_snap", 64'(tail_snap), 64'(c_tl % 32));
        chk("err", 64'(err), 64'(m_err));
        c_dv = (c_sz > 0) && (mq[0].st == 3);
        chk("drain_valid", 64'(drain_valid), 64'(c_dv));
        if (c_dv) begin
          chk("drain_addr", 64'(drain_addr), 64'(mq[0].a));
          chk("drain_data", 64'(drain_data), 64'(mq[0].d));
          chk("drain_be", 64'(drain_be), 64'(mq[0].be));
        end
        model_fwd(e_hit, e_stall, e_data);
        chk("fwd_hit", 64'(fwd_hit), 64'(e_hit));
        chk("fwd_stall", 64'(fwd_stall), 64'(e_stall));
        if (e_hit || !ld_valid) chk("fwd_data", 64'(fwd_data), 64'(e_data));

        c_ke  = (int'(exec_tag) - (m_head % DEPTH) + DEPTH) % DEPTH;
        c_eok = exec_valid && c_ke < c_sz && mq[c_ke].st == 1;
        c_cok = commit_valid && m_ncmt < c_sz && mq[m_ncmt].st == 2;
        c_aok = alloc_valid && c_sz < DEPTH && !flush;
        c_dok = c_dv && drain_ready;
        if (exec_valid && !c_eok) m_err = 1;
        if (commit_valid && !c_cok) m_err = 1;
        if (c_eok) begin
          mq[c_ke].st = 2;
          mq[c_ke].a  = exec_addr;
          mq[c_ke].d  = exec_data;
          mq[c_ke].be = exec_be;
        end
        if (c_cok) begin
          mq[m_ncmt].st = 3;
          m_ncmt++;
        end
        if (flush) while (mq.size() > m_ncmt) void'(mq.pop_back());
        if (c_dok) begin
          n_drained++;
          $display("drain #%0d addr=%02h data=%08h be=%h", n_drained, mq[0].a, mq[0].d, mq[0].be);
          void'(mq.pop_front());
          m_head++;
          m_ncmt--;
        end
        if (c_aok) begin
          c_new.st = 1; c_new.a = '0; c_new.d = '0; c_new.be = '0;
          mq.push_back(c_new);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc1(output logic [TW-1:0] t);
    t = TW'(m_tail() % DEPTH);
    alloc_valid = 1; tick(); alloc_valid = 0;
  endtask

  task automatic exec1(input logic [TW-1:0] t, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
    exec_valid = 1; exec_tag = t; exec_addr = a; exec_data = d; exec_be = be;
    tick();
    exec_valid = 0;
  endtask

  task automatic commit1();
    commit_valid = 1; tick(); commit_valid = 0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    logic [AW-1:0] base;
    case ($urandom % 4)
      0: base = 8'h40;
      1: base = 8'h44;
      2: base = 8'h48;
      default: base = 8'h80;
    endcase
    return base | AW'($urandom % 4);
  endfunction

  function automatic logic [BW-1:0] rand_be();
    return BW'($urandom_range(1, 15));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  logic [TW-1:0] t0;
  int            r_sz, r_k;
  int            aq[$];

  initial begin
    n_cmp = 0; n_bad = 0; n_drained = 0;
    rstn = 0;
    alloc_valid = 0; exec_valid = 0; exec_tag = '0; exec_addr = '0; exec_data = '0; exec_be = '0;
    commit_valid = 0; drain_ready = 0; ld_valid = 0; ld_addr = '0; ld_be = '0; ld_age = '0;
    flush = 0;

    // Values held while in reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_drain_valid", 64'(drain_valid), 64'd0);
    chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    chk("rst_fwd_stall", 64'(fwd_stall), 64'd0);
    chk("rst_fwd_data", 64'(fwd_data), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    tick();
    rstn = 1;
    tick();

    // Fill to 16, 17th refused, drain one reopens allocation
    alloc_valid = 1;
    repeat (16) tick();
    @(negedge clk);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_alloc_ready", 64'(alloc_ready), 64'd0);
    chk("fill_count", 64'(count), 64'd16);
    tick();
    alloc_valid = 0;
    for (int i = 0; i < 16; i++) exec1(TW'(i), AW'(8'h10 + 4 * i), $urandom, 4'hF);
    repeat (16) commit1();
    drain_ready = 1; tick(); drain_ready = 0;
    @(negedge clk);
    chk("after_drain_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("after_drain_count", 64'(count), 64'd15);
    tick();
    drain_ready = 1; repeat (15) tick(); drain_ready = 0;
    @(negedge clk);
    chk("fill_drained_empty", 64'(empty), 64'd1);
    tick();

    // Full-cover forward of a committed store
    alloc1(t0);
    exec1(t0, 8'h44, 32'hDEADBEEF, 4'b1111);
    commit1();
    ld_valid = 1; ld_addr = 8'h44; ld_be = 4'b0011; ld_age = (TW+1)'(m_tail() % 32);
    @(negedge clk);
    chk("fwd_full_hit", 64'(fwd_hit), 64'd1);
    chk("fwd_full_data", 64'(fwd_data), 64'hDEADBEEF);
    chk("fwd_full_stall", 64'(fwd_stall), 64'd0);
    tick();
    ld_valid = 0;

    // Partial cover stalls; an older ALLOC stalls any address; age mask excludes younger
    alloc1(t0);
    exec1(t0, 8'h44, 32'h11223344, 4'b0001);
    commit1();
    ld_valid = 1; ld_addr = 8'h44; ld_be = 4'b1111; ld_age = (TW+1)'(m_tail() % 32);
    @(negedge clk);
    chk("fwd_partial_stall", 64'(fwd_stall), 64'd1);
    chk("fwd_partial_hit", 64'(fwd_hit), 64'd0);
    tick();
    alloc1(t0);
    ld_addr = 8'h80; ld_age = (TW+1)'(m_tail() % 32);
    @(negedge clk);
    chk("fwd_alloc_stall", 64'(fwd_stall), 64'd1);
    tick();
    ld_age = (TW+1)'((m_tail() - 1) % 32);
    @(negedge clk);
    chk("fwd_masked_stall", 64'(fwd_stall), 64'd0);
    chk("fwd_masked_hit", 64'(fwd_hit), 64'd0);
    tick();
    ld_valid = 0;
    flush = 1; tick(); flush = 0;
    drain_ready = 1; repeat (2) tick(); drain_ready = 0;
    @(negedge clk);
    chk("fwd_phase_empty", 64'(empty), 64'd1);
    tick();

    // Alloc 4, exec 4, commit 2, flush leaves 2 to drain
    alloc_valid = 1; repeat (4) tick(); alloc_valid = 0;
    for (int i = 0; i < 4; i++) exec1(TW'((m_head + i) % DEPTH), AW'(8'h20 + 4 * i), $urandom, 4'hF);
    repeat (2) commit1();
    flush = 1; tick(); flush = 0;
    @(negedge clk);
    chk("flush_count", 64'(count), 64'd2);
    tick();
    drain_ready = 1; repeat (2) tick(); drain_ready = 0;
    @(negedge clk);
    chk("flush_drained_empty", 64'(empty), 64'd1);
    tick();

    // Commit and flush together keep the committed entry
    alloc_valid = 1; repeat (2) tick(); alloc_valid = 0;
    for (int i = 0; i < 2; i++) exec1(TW'((m_head + i) % DEPTH), 8'h30, $urandom, 4'hF);
    commit_valid = 1; flush = 1; tick(); commit_valid = 0; flush = 0;
    @(negedge clk);
    chk("commit_flush_count", 64'(count), 64'd1);
    tick();
    drain_ready = 1; tick(); drain_ready = 0;

    // Randomized mix with toggling drain_ready, wrapping the pointers many times
    for (int cyc = 0; cyc < 800; cyc++) begin
      r_sz = mq.size();
      alloc_valid = ($urandom % 3) != 0;
      exec_valid = 0;
      aq.delete();
      for (int k = 0; k < r_sz; k++) if (mq[k].st == 1) aq.push_back(k);
      if (aq.size() > 0 && ($urandom % 4) != 0) begin
        r_k = aq[$urandom % aq.size()];
        exec_valid = 1;
        exec_tag   = TW'((m_head + r_k) % DEPTH);
        exec_addr  = pick_addr();
        exec_data  = $urandom;
        exec_be    = rand_be();
      end
      commit_valid = (m_ncmt < r_sz) && (mq[m_ncmt].st == 2) && (($urandom % 3) != 0);
      flush        = ($urandom % 50) == 0;
      drain_ready  = $urandom % 2;
      ld_valid     = $urandom % 2;
      r_k          = $urandom_range(0, r_sz);
      ld_age       = (TW+1)'((m_head + r_k) % 32);
      ld_addr      = pick_addr();
      ld_be        = rand_be();
      tick();
    end
    alloc_valid = 0; exec_valid = 0; commit_valid = 0; ld_valid = 0;
    flush = 1; tick(); flush = 0;
    drain_ready = 1; repeat (16) tick(); drain_ready = 0;
    @(negedge clk);
    chk("random_final_empty", 64'(empty), 64'd1);
    tick();

    // Illegal commit of an ALLOC entry sets a sticky error until reset
    alloc1(t0);
    commit1();
    @(negedge clk);
    chk("err_set", 64'(err), 64'd1);
    tick();
    repeat (3) tick();
    @(negedge clk);
    chk("err_sticky", 64'(err), 64'd1);
    tick();
    rstn = 0;
    @(negedge clk);
    chk("err_cleared", 64'(err), 64'd0);
    chk("reset_empty", 64'(empty), 64'd1);
    tick();
    rstn = 1;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_buffer_fwd.md
STORE_BUFFER_FWD -- requirements
Module: store_buffer_fwd

Interface
REQ-001 Parameters: DEPTH, default 16, number of entries (power of 2, ≥2); ADDR_W, default 8, byte address width; DATA_W, default 32, data width (multiple of 8); TAG_W = log2(DEPTH).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low; ports are clk and rstn.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 alloc_valid  in  1  decode requests a store entry; alloc_ready  out  1  entry available; alloc_tag  out  TAG_W  index granted.
REQ-006 exec_valid  in  1; exec_tag  in  TAG_W; exec_addr  in  ADDR_W; exec_data  in  DATA_W; exec_be  in  DATA_W/8  execute-stage address/data/byte-enable write.
REQ-007 commit_valid  in  1  ROB retires the oldest uncommitted store.
REQ-008 drain_valid  out  1; drain_addr  out  ADDR_W; drain_data  out  DATA_W; drain_be  out  DATA_W/8; drain_ready  in  1  memory write handshake.
REQ-009 ld_valid  in  1; ld_addr  in  ADDR_W; ld_be  in  DATA_W/8; ld_age  in  TAG_W+1  tail snapshot taken at load decode.
REQ-010 fwd_hit  out  1; fwd_data  out  DATA_W; fwd_stall  out  1  forwarding result.
REQ-011 flush  in  1  discard all uncommitted entries.
REQ-012 tail_snap  out  TAG_W+1; count  out  TAG_W+1; full  out  1; empty  out  1; err  out  1  sticky protocol error.

Function
REQ-013 Circular buffer with head (oldest), cmt (first uncommitted) and tail pointers, each TAG_W+1 bits; the wrap bit distinguishes full from empty.
REQ-014 Per-entry states: FREE -> ALLOC (on alloc) -> READY (on exec) -> COMMITTED (on commit) -> FREE (on drain handshake).
REQ-015 alloc_ready = !full && !flush; on alloc_valid&&alloc_ready, the entry at tail becomes ALLOC, alloc_tag = tail[TAG_W-1:0], tail increments the next cycle.
REQ-016 exec_valid to an ALLOC entry stores addr/data/be and sets READY; exec_valid to any other state is ignored and sets err.
REQ-017 commit_valid with entry[cmt] READY sets it COMMITTED and increments cmt; with entry[cmt] not READY, or cmt==tail, it is ignored and sets err.
REQ-018 drain_valid = entry[head] COMMITTED; drain_* is presented from entry[head]; on drain_valid&&drain_ready, the entry becomes FREE and head increments; drain_* holds stable while drain_valid&&!drain_ready.
REQ-019 Forwarding is combinational (0-cycle); candidates are entries from head up to but excluding ld_age, in any non-FREE state.
REQ-020 Word match: addr[ADDR_W-1:log2(DATA_W/8)] equal and (be & ld_be)!=0.
REQ-021 If any candidate is ALLOC, fwd_stall=1 and fwd_hit=0.
REQ-022 Otherwise the youngest matching candidate is selected: if its be covers ld_be, fwd_hit=1 and fwd_data is that entry's data; if it covers ld_be only partially, fwd_stall=1; with no match, fwd_hit=fwd_stall=0.
REQ-023 When ld_valid=0, fwd_hit=fwd_stall=0 and fwd_data=0.
REQ-024 flush: tail<=cmt, all ALLOC/READY entries become FREE, and COMMITTED entries keep draining; an alloc in the same cycle is dropped.
REQ-025 Commit and flush in the same cycle: the commit is applied first, then tail<=cmt+1.
REQ-026 Drain and alloc in the same cycle are both honoured; full is computed from registered pointers (no same-cycle bypass).
REQ-027 count = tail-head; full = (count==DEPTH); empty = (count==0); tail_snap = tail.

Reset
REQ-028 On rstn=0, asynchronously: all entries FREE; head=cmt=tail=0; err=0.
REQ-029 Output values during and after reset: alloc_ready=1, empty=1, full=0, count=0, drain_valid=0, fwd_hit=fwd_stall=0, fwd_data=0.
REQ-030 Reset mid-drain abandons the entry; no retry is performed.

Structure
REQ-031 The shared package holds the entry-state enum (FREE/ALLOC/READY/COMMITTED) and the clog2-derived width constants.
REQ-032 One sub-module, sq_fwd_select, performs the age-masked youngest-match priority search; it is purely combinational.

Verification
REQ-033 Allocate 16 stores, then attempt a 17th -> alloc_ready=0 and full=1; drain one -> alloc_ready=1 the next cycle.
REQ-034 Store 0x44 be=1111 data=0xDEADBEEF committed; load 0x44 be=0011 with ld_age after it -> fwd_hit=1, fwd_data=0xDEADBEEF.
REQ-035 Store 0x44 be=0001 then load 0x44 be=1111 -> fwd_stall=1; an older ALLOC entry -> fwd_stall=1 regardless of address.
REQ-036 Alloc 4, exec 4, commit 2, flush -> tail=cmt=2; 2 drains occur and then empty=1.
REQ-037 Wrap: 40 alloc/exec/commit/drain cycles with drain_ready toggling -> data is drained in order, with no loss or duplication.
REQ-038 Commit with entry[cmt] ALLOC -> err=1, which remains set until rstn.
